// File: rtl/mul_iter_multi.sv
// Iterative multiplier retiring STEP multiplier bits per cycle for MUL/MULH/MULHSU/MULHU.
// It has a valid/ready request and result, carries a tag through, and can be flushed mid-operation.
module mul_iter_multi #(
    parameter int XLEN  = 32,
    parameter int STEP  = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int NCH = XLEN / STEP;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = 2 * XLEN + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN:0]     a_q, a_d;
    logic [XLEN:0]     b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    logic [STEP-1:0]   chunk;
    logic              top_neg;
    logic [AW-1:0]     a_ext;
    logic [AW-1:0]     pp;
    logic [AW-1:0]     acc_run;
    logic [AW-1:0]     term [STEP];

    assign in_ready   = (state_q == S_IDLE) & ~flush;
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign out_tag    = out_tag_q;

    // Chunks are consumed MSB-first (Horner form), so the signed top chunk comes first.
    assign chunk   = STEP'(b_q[XLEN-1:0] >> (32'(cnt_q) * STEP));
    assign top_neg = b_q[XLEN] & (cnt_q == CW'(NCH - 1));
    assign a_ext   = {{XLEN{a_q[XLEN]}}, a_q};

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_term
            assign term[gi] = chunk[gi] ? (a_ext << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp = '0;
        for (int j = 0; j < STEP; j++) begin
            // A negative signed b gives its bit XLEN-1 a weight of -2^(XLEN-1).
            if (j == STEP - 1 && top_neg)
                pp = pp - term[j];
            else
                pp = pp + term[j];
        end
        acc_run = (acc_q << STEP) + pp;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tag_d     = tag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_d     = {(in_op != 2'b11) & in_a[XLEN-1], in_a};
                        b_d     = {~in_op[1] & in_b[XLEN-1], in_b};
                        op_d    = in_op;
                        tag_d   = in_tag;
                        acc_d   = '0;
                        cnt_d   = CW'(NCH - 1);
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d = acc_run;
                    if (cnt_q == '0) begin
                        state_d   = S_DONE;
                        result_d  = (op_q == 2'b00) ? acc_run[XLEN-1:0] : acc_run[2*XLEN-1:XLEN];
                        out_tag_d = tag_q;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end
endmodule
